key_schedule: RTL

Sequencer that produces the full AES-128 key schedule from a 128-bit cipher key. It iterates a single instance of the one-round key-expansion block (genRoundKey) over rounds 1 to 10 and stores all 11 round keys in an internal table. The cipher datapath downstream reads the table by round index. It sits between the key input (SPI receive register) and the AES round datapath, and it must finish before the cipher begins round 0.

---
 rtl/key_schedule.sv | 178 +++++++++++++++++
 1 files changed

// File: rtl/key_schedule.sv
// AES-128 key schedule sequencer: iterates one key-expansion round block over
// rounds 1..NROUNDS and keeps every round key in a table readable by index.
`timescale 1ns/1ps

module gen_round_key (
    input  logic         clk,
    input  logic         reset,
    input  logic [127:0] previous_key_i,
    input  logic [3:0]   round_i,
    output logic [127:0] round_key_o
);
    // Forward S-box, byte 0x00 in the most significant position.
    localparam logic [2047:0] SBOX = {
        128'h637c777bf26b6fc53001672bfed7ab76,
        128'hca82c97dfa5947f0add4a2af9ca472c0,
        128'hb7fd9326363ff7cc34a5e5f171d83115,
        128'h04c723c31896059a071280e2eb27b275,
        128'h09832c1a1b6e5aa0523bd6b329e32f84,
        128'h53d100ed20fcb15b6acbbe394a4c58cf,
        128'hd0efaafb434d338545f9027f503c9fa8,
        128'h51a3408f929d38f5bcb6da2110fff3d2,
        128'hcd0c13ec5f974417c4a77e3d645d1973,
        128'h60814fdc222a908846eeb814de5e0bdb,
        128'he0323a0a4906245cc2d3ac629195e479,
        128'he7c8376d8dd54ea96c56f4ea657aae08,
        128'hba78252e1ca6b4c6e8dd741f4bbd8b8a,
        128'h703eb5664803f60e613557b986c11d9e,
        128'he1f8981169d98e949b1e87e9ce5528df,
        128'h8ca1890dbfe6426841992d0fb054bb16
    };

    function automatic logic [7:0] sbox(input logic [7:0] x);
        return SBOX[{~x, 3'b000} +: 8];
    endfunction

    function automatic logic [7:0] rcon(input logic [3:0] r);
        case (r)
            4'd1:    return 8'h01;
            4'd2:    return 8'h02;
            4'd3:    return 8'h04;
            4'd4:    return 8'h08;
            4'd5:    return 8'h10;
            4'd6:    return 8'h20;
            4'd7:    return 8'h40;
            4'd8:    return 8'h80;
            4'd9:    return 8'h1b;
            4'd10:   return 8'h36;
            default: return 8'h00;
        endcase
    endfunction

    logic [31:0]  w0, w1, w2, w3, temp;
    logic [127:0] round_key_d, round_key_q;

    always_comb begin
        w0   = previous_key_i[127:96];
        w1   = previous_key_i[95:64];
        w2   = previous_key_i[63:32];
        w3   = previous_key_i[31:0];
        // RotWord then SubWord on the last word, then XOR round constant.
        temp = {sbox(w3[23:16]), sbox(w3[15:8]), sbox(w3[7:0]), sbox(w3[31:24])}
               ^ {rcon(round_i), 24'h000000};
        round_key_d[127:96] = w0 ^ temp;
        round_key_d[95:64]  = w1 ^ w0 ^ temp;
        round_key_d[63:32]  = w2 ^ w1 ^ w0 ^ temp;
        round_key_d[31:0]   = w3 ^ w2 ^ w1 ^ w0 ^ temp;
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) round_key_q <= '0;
        else       round_key_q <= round_key_d;
    end

    assign round_key_o = round_key_q;
endmodule

module key_schedule #(
    parameter int NROUNDS = 10
) (
    input  logic         clk,
    input  logic         reset,
    input  logic         start,
    input  logic [127:0] key,
    input  logic [3:0]   rd_round,
    output logic [127:0] rd_key,
    output logic         busy,
    output logic         done
);
    localparam logic [3:0] LAST_RND = 4'(NROUNDS);

    typedef enum logic [1:0] {IDLE, ISSUE, CAPTURE, DONE} state_t;

    state_t       state_q, state_d;
    logic [3:0]   rnd_q, rnd_d;
    logic [127:0] prev_q, prev_d;
    logic [127:0] round_key;
    logic         load_en, cap_en;
    logic [127:0] table_q [0:NROUNDS];
    logic [127:0] rd_mux  [0:15];

    gen_round_key u_round (
        .clk            (clk),
        .reset          (reset),
        .previous_key_i (prev_q),
        .round_i        (rnd_q),
        .round_key_o    (round_key)
    );

    always_comb begin
        state_d = state_q;
        rnd_d   = rnd_q;
        prev_d  = prev_q;
        load_en = 1'b0;
        cap_en  = 1'b0;
        case (state_q)
            IDLE, DONE: begin
                if (start) begin
                    load_en = 1'b1;
                    prev_d  = key;
                    rnd_d   = 4'd1;
                    state_d = ISSUE;
                end
            end
            ISSUE: state_d = CAPTURE;
            CAPTURE: begin
                cap_en = 1'b1;
                prev_d = round_key;
                if (rnd_q == LAST_RND) begin
                    state_d = DONE;
                end else begin
                    rnd_d   = rnd_q + 4'd1;
                    state_d = ISSUE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q <= IDLE;
            rnd_q   <= '0;
            prev_q  <= '0;
        end else begin
            state_q <= state_d;
            rnd_q   <= rnd_d;
            prev_q  <= prev_d;
        end
    end

    // Entry 0 is written by the load step, entries 1..NROUNDS by CAPTURE.
    generate
        for (genvar gi = 0; gi <= NROUNDS; gi++) begin : g_table
            if (gi == 0) begin : g_key
                always_ff @(posedge clk or posedge reset) begin
                    if (reset)        table_q[gi] <= '0;
                    else if (load_en) table_q[gi] <= key;
                end
            end else begin : g_round
                always_ff @(posedge clk or posedge reset) begin
                    if (reset)                            table_q[gi] <= '0;
                    else if (cap_en && rnd_q == 4'(gi))   table_q[gi] <= round_key;
                end
            end
        end
        for (genvar gi = 0; gi < 16; gi++) begin : g_rd
            if (gi <= NROUNDS) begin : g_valid
                assign rd_mux[gi] = table_q[gi];
            end else begin : g_zero
                assign rd_mux[gi] = '0;
            end
        end
    endgenerate

    assign rd_key = rd_mux[rd_round];
    assign busy   = (state_q == ISSUE) || (state_q == CAPTURE);
    assign done   = (state_q == DONE);
endmodule
